queue_motion_ctrl: RTL and testbench
====================================

Name: queue_motion_ctrl

Overview:
- Per-frame player controller directly upstream of the player sprite renderer.
- Turns raw button inputs into the renderer's inputs:
  - sprite centre position (posX, posY)
  - game state (INITIAL/PLAYING)
  - facing bit (animation_state: LEFT/RIGHT)
- Updates once per video frame on a frame_tick pulse, so the drawn sprite never changes mid-scan.

Parameters:
- START_X, 100: posX after reset.
- X_MIN, 22: leftmost legal posX (half sprite width).
- X_MAX, 617: rightmost legal posX.
- Y_MIN, 25: topmost legal posY (half sprite height).
- GROUND_Y, 400: resting posY, also posY after reset.
- STEP_X, 4: horizontal pixels moved per frame while a direction is held.
- JUMP_V0, 12: initial upward velocity (pixels/frame).
- GRAVITY, 1: velocity decrement per frame while airborne.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per frame (end of visible area).
- btn_left  in  1  raw, asynchronous, level.
- btn_right  in  1  raw, asynchronous, level.
- btn_jump  in  1  raw, asynchronous, level.
- btn_start  in  1  raw, asynchronous, level.
- posX  out  10  sprite centre X.
- posY  out  9  sprite centre Y.
- state  out  1  0 = QUEUE_INITIAL, 1 = QUEUE_PLAYING.
- animation_state  out  1  0 = QUEUE_LEFT, 1 = QUEUE_RIGHT.
- airborne  out  1  1 while jumping or falling.

Behaviour:
- Reset (rst high at a clk edge):
  - state=INITIAL, posX=START_X, posY=GROUND_Y, animation_state=RIGHT, airborne=0.
  - vy=0; jump latch cleared; synchronizers cleared.
  - Reset wins over every other event, including mid-jump: the next cycle shows reset values.
- Input synchronization:
  - Every button passes through a 2-flop synchronizer; "pressed" below means the synchronized value.
  - btn_jump rising edge (synchronized) sets jump_req.
  - jump_req stays set until consumed at the next frame_tick, so pulses between ticks are not lost.
- Top FSM:
  - INITIAL -> PLAYING on any cycle with btn_start pressed; state changes the following cycle.
  - PLAYING has no exit except rst.
  - In INITIAL: position, velocity and facing are frozen, and jump_req is held cleared.
- Timing of updates: all motion registers change only in the cycle after a clk edge where frame_tick=1 and state=PLAYING. Outputs are registered; 1-cycle latency from the tick.
- Horizontal motion (per tick):
  - Left only: posX = max(posX-STEP_X, X_MIN), facing=LEFT.
  - Right only: posX = min(posX+STEP_X, X_MAX), facing=RIGHT.
  - Both or neither: posX and facing unchanged.
  - Compute in 11 bits so no wrap-around occurs below 0 or above 1023.
- Vertical sub-FSM (GROUND / AIR), vy a signed 7-bit register, upward positive:
  - GROUND + jump_req at tick: vy=JUMP_V0-GRAVITY, posY=GROUND_Y-JUMP_V0, go AIR, airborne=1.
  - AIR at tick: ny = posY - vy (signed, 11 bits).
    - ny >= GROUND_Y: posY=GROUND_Y, vy=0, go GROUND, airborne=0 (landing).
    - ny < Y_MIN: posY=Y_MIN, vy=-GRAVITY (ceiling hit).
    - Otherwise: posY=ny, vy=vy-GRAVITY.
  - jump_req is cleared at every PLAYING tick; it is consumed only in GROUND, so jumps while in AIR are ignored.
- Horizontal and vertical updates on the same tick are independent and simultaneous.

Test Plan:
- Reset check: rst for 2 cycles -> posX=100, posY=400, state=0, animation_state=1, airborne=0. frame_ticks while in INITIAL leave all outputs unchanged.
- Start and walk right: btn_start pulse -> state=1 within 3 cycles. Then btn_right held across 3 ticks -> posX=112, animation_state=1.
- Left clamp: from posX=30, btn_left held for 3 ticks -> posX=26, then 22, then 22; animation_state=0. Both buttons held -> posX and facing unchanged.
- Jump trajectory: 1-cycle btn_jump pulse between ticks.
  - Next tick: posY=388, airborne=1.
  - After 12 ticks: posY=322.
  - Tick 13: posY=322.
  - Tick 25: posY=400, airborne=0.
  - Second jump pulse at tick 5 is ignored.
- Jump plus right: jump with btn_right held -> posX advances 4 per tick throughout the flight, independent of posY.
- Reset mid-jump: assert rst at tick 8 of a jump -> next cycle posY=400, airborne=0, state=0. A later jump after restart follows the full profile again.

Source files
------------

// File: rtl/queue_motion_ctrl.sv
// Per-frame player motion controller: synchronizes buttons, runs the start FSM and
// updates sprite position, facing and jump physics once per frame_tick.
module queue_motion_ctrl #(
    parameter int START_X  = 100,
    parameter int X_MIN    = 22,
    parameter int X_MAX    = 617,
    parameter int Y_MIN    = 25,
    parameter int GROUND_Y = 400,
    parameter int STEP_X   = 4,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_start,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic       state,
    output logic       animation_state,
    output logic       airborne
);

    typedef enum logic {QUEUE_INITIAL = 1'b0, QUEUE_PLAYING = 1'b1} top_state_t;
    typedef enum logic {V_GROUND = 1'b0, V_AIR = 1'b1} v_state_t;

    localparam logic              QUEUE_LEFT  = 1'b0;
    localparam logic              QUEUE_RIGHT = 1'b1;
    localparam logic signed [10:0] STEP_S     = 11'(STEP_X);
    localparam logic signed [10:0] XMIN_S     = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S     = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S     = 11'(Y_MIN);
    localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);
    localparam logic signed [6:0]  GRAV_V     = 7'(GRAVITY);

    top_state_t top_q;
    v_state_t   v_q;
    logic [3:0] sync1, sync2;   // {start, jump, right, left}
    logic       jump_prev;
    logic       jump_req;
    logic signed [6:0] vy;

    logic              left_p, right_p, jump_p, start_p, jump_rise;
    logic signed [10:0] x_ext, x_dec, x_inc, y_ext, vy_ext, ny;

    assign state = top_q;

    always_comb begin
        left_p    = sync2[0];
        right_p   = sync2[1];
        jump_p    = sync2[2];
        start_p   = sync2[3];
        jump_rise = jump_p & ~jump_prev;
        x_ext     = $signed({1'b0, posX});
        x_dec     = x_ext - STEP_S;
        x_inc     = x_ext + STEP_S;
        y_ext     = $signed({2'b00, posY});
        vy_ext    = {{4{vy[6]}}, vy};
        ny        = y_ext - vy_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q           <= QUEUE_INITIAL;
            v_q             <= V_GROUND;
            sync1           <= '0;
            sync2           <= '0;
            jump_prev       <= 1'b0;
            jump_req        <= 1'b0;
            vy              <= '0;
            posX            <= 10'(START_X);
            posY            <= 9'(GROUND_Y);
            animation_state <= QUEUE_RIGHT;
            airborne        <= 1'b0;
        end else begin
            sync1     <= {btn_start, btn_jump, btn_right, btn_left};
            sync2     <= sync1;
            jump_prev <= jump_p;

            if (top_q == QUEUE_INITIAL) begin
                jump_req <= 1'b0;
                if (start_p) top_q <= QUEUE_PLAYING;
            end else begin
                // A rising edge on the tick cycle itself is kept for the next frame.
                if (jump_rise)       jump_req <= 1'b1;
                else if (frame_tick) jump_req <= 1'b0;

                if (frame_tick) begin
                    if (left_p && !right_p) begin
                        posX            <= (x_dec < XMIN_S) ? 10'(X_MIN) : x_dec[9:0];
                        animation_state <= QUEUE_LEFT;
                    end else if (right_p && !left_p) begin
                        posX            <= (x_inc > XMAX_S) ? 10'(X_MAX) : x_inc[9:0];
                        animation_state <= QUEUE_RIGHT;
                    end

                    case (v_q)
                        V_GROUND: begin
                            if (jump_req) begin
                                vy       <= 7'(JUMP_V0 - GRAVITY);
                                posY     <= 9'(GROUND_Y - JUMP_V0);
                                v_q      <= V_AIR;
                                airborne <= 1'b1;
                            end
                        end
                        V_AIR: begin
                            if (ny >= GROUND_S) begin
                                posY     <= 9'(GROUND_Y);
                                vy       <= '0;
                                v_q      <= V_GROUND;
                                airborne <= 1'b0;
                            end else if (ny < YMIN_S) begin
                                posY <= 9'(Y_MIN);
                                vy   <= -GRAV_V;
                            end else begin
                                posY <= ny[8:0];
                                vy   <= vy - GRAV_V;
                            end
                        end
                        default: v_q <= V_GROUND;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_queue_motion_ctrl.sv
// Directed bench for queue_motion_ctrl: reset, start, walking, clamps, jump profile
// and reset during flight, each checked against hand-computed values.
module tb_queue_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_jump, btn_start;
    logic [9:0] posX;
    logic [8:0] posY;
    logic       state, animation_state, airborne;

    int checks = 0;
    int errors = 0;

    // posY after jump ticks 1..25 (vy starts at 11 after the launch tick).
    int jump_y[25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322,
                       323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    queue_motion_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_start(btn_start),
        .posX(posX), .posY(posY), .state(state),
        .animation_state(animation_state), .airborne(airborne)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Settle synchronizers, then a one-cycle tick; outputs are sampled at the following negedge.
    task automatic tick();
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clk); btn_jump = 1'b1;
        @(negedge clk); btn_jump = 1'b0;
    endtask

    task automatic press_start();
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_posX", 32'(posX), 100);
        chk("rst_posY", 32'(posY), 400);
        chk("rst_state", 32'(state), 0);
        chk("rst_facing", 32'(animation_state), 1);
        chk("rst_airborne", 32'(airborne), 0);

        // Ticks in INITIAL are ignored, even with a direction held.
        btn_left = 1'b1;
        tick(); tick();
        chk("init_posX", 32'(posX), 100);
        chk("init_facing", 32'(animation_state), 1);
        chk("init_state", 32'(state), 0);
        btn_left = 1'b0;

        press_start();
        chk("start_state", 32'(state), 1);

        btn_right = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("walk_right_posX", 32'(posX), 32'(100 + 4 * i));
        end
        chk("walk_right_facing", 32'(animation_state), 1);

        // 112 walks down to 24 in 22 ticks, the 23rd clamps at 22.
        btn_right = 1'b0; btn_left = 1'b1;
        repeat (23) tick();
        chk("walk_left_posX", 32'(posX), 22);
        chk("walk_left_facing", 32'(animation_state), 0);

        btn_left = 1'b0; btn_right = 1'b1;
        tick(); tick();
        chk("to30_posX", 32'(posX), 30);

        btn_right = 1'b0; btn_left = 1'b1;
        tick(); chk("lclamp1_posX", 32'(posX), 26);
        tick(); chk("lclamp2_posX", 32'(posX), 22);
        tick(); chk("lclamp3_posX", 32'(posX), 22);
        chk("lclamp_facing", 32'(animation_state), 0);

        btn_right = 1'b1;
        tick(); tick();
        chk("both_posX", 32'(posX), 22);
        chk("both_facing", 32'(animation_state), 0);
        btn_left = 1'b0; btn_right = 1'b0;

        // Full jump, with an extra jump pulse before tick 5 that must be ignored.
        pulse_jump();
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) pulse_jump();
            tick();
            chk("jump_posY", 32'(posY), 32'(jump_y[i-1]));
            chk("jump_airborne", 32'(airborne), (i < 25) ? 32'd1 : 32'd0);
        end
        tick();
        chk("after_jump_posY", 32'(posY), 400);
        chk("after_jump_airborne", 32'(airborne), 0);
        chk("after_jump_posX", 32'(posX), 22);

        // Jump while walking right: horizontal motion is independent of flight.
        btn_right = 1'b1;
        pulse_jump();
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk("jr_posX", 32'(posX), 32'(22 + 4 * i));
            chk("jr_posY", 32'(posY), 32'(jump_y[i-1]));
        end
        chk("jr_facing", 32'(animation_state), 1);

        // 122 reaches 614 after 123 ticks; the 124th clamps at 617.
        repeat (123) tick();
        chk("rclamp_pre_posX", 32'(posX), 614);
        tick();
        chk("rclamp_posX", 32'(posX), 617);
        tick();
        chk("rclamp_hold_posX", 32'(posX), 617);
        btn_right = 1'b0;

        // Reset coincident with jump tick 8.
        pulse_jump();
        repeat (7) tick();
        chk("midjump_posY", 32'(posY), 337);
        repeat (3) @(negedge clk);
        frame_tick = 1'b1; rst = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; rst = 1'b0;
        chk("midrst_posY", 32'(posY), 400);
        chk("midrst_airborne", 32'(airborne), 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_posX", 32'(posX), 100);
        chk("midrst_facing", 32'(animation_state), 1);

        // A jump pressed in INITIAL is not remembered across start.
        pulse_jump();
        press_start();
        chk("restart_state", 32'(state), 1);
        tick();
        chk("init_jump_posY", 32'(posY), 400);
        chk("init_jump_airborne", 32'(airborne), 0);

        pulse_jump();
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk("rejump_posY", 32'(posY), 32'(jump_y[i-1]));
        end
        chk("rejump_airborne", 32'(airborne), 0);
        chk("rejump_posX", 32'(posX), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
